keypad_entry: RTL and testbench



---
 rtl/keypad_entry.sv | 251 +++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// ---------------------------------------------------------------------------
// keypad_entry
//
// Samples a one-hot keypad, debounces it and turns every accepted press into
// a 4-bit digit with a one-cycle strobe. Accepted digits are shifted into a
// DIGITS-deep BCD entry buffer (newest digit in the low nibble).
//
// Parameters:
//   KEYS            number of keypad lines (2..16); key i encodes digit i
//   DEBOUNCE_CYCLES consecutive identical samples required after the first
//   DIGITS          depth of the entry buffer in 4-bit digits
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   keypad       in   raw key lines (1 = pressed), asynchronous and bouncy
//   clear        in   synchronous clear of entry/count
//   digit_valid  out  one-cycle strobe for an accepted press
//   digit        out  value of the last accepted key, held between strobes
//   entry        out  digit buffer, newest in [3:0]
//   count        out  number of valid digits in entry, saturating at DIGITS
//   multi_err    out  one-cycle strobe for a rejected multi-key press
//
// Optional feature macro: KEYPAD_MULTI_ERR_EN
//   defined   -> a stable multi-key sample is rejected and flagged on multi_err
//   undefined -> the highest pressed key wins and multi_err stays 0
// ---------------------------------------------------------------------------
module keypad_entry #(
    parameter int KEYS            = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [KEYS-1:0]                keypad,
    input  logic                           clear,
    output logic                           digit_valid,
    output logic [3:0]                     digit,
    output logic [4*DIGITS-1:0]            entry,
    output logic [$clog2(DIGITS+1)-1:0]    count,
    output logic                           multi_err
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS   = 3'd1,
        S_ACCEPT  = 3'd2,
        S_HELD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [KEYS-1:0]     r_ksmp;
    logic [KEYS-1:0]     r_kprev;
    logic [SW-1:0]       r_stable_cnt;
    logic [SW-1:0]       w_stable_cnt;
    logic                w_stable;
    logic                w_sample_nz;
    logic                w_accept;
    logic [3:0]          w_enc;
    logic [4*DIGITS-1:0] w_entry_shift;

    logic                r_digit_valid;
    logic [3:0]          r_digit;
    logic [4*DIGITS-1:0] r_entry;
    logic [CW-1:0]       r_count;
    logic                r_multi_err;

`ifdef KEYPAD_MULTI_ERR_EN
    logic                w_reject;
`endif

    // Index of the highest set bit; 0 for an all-zero sample.
    function automatic logic [3:0] f_encode(input logic [KEYS-1:0] k);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < KEYS; i++) begin
            if (k[i]) begin
                v = 4'(i);
            end
        end
        return v;
    endfunction

`ifdef KEYPAD_MULTI_ERR_EN
    // True when more than one bit of the sample is set.
    function automatic logic f_multi_hot(input logic [KEYS-1:0] k);
        return (k & (k - {{(KEYS-1){1'b0}}, 1'b1})) != {KEYS{1'b0}};
    endfunction
`endif

    assign w_sample_nz = |r_ksmp;
    assign w_enc       = f_encode(r_ksmp);
    assign w_stable    = (w_stable_cnt == SW'(DEBOUNCE_CYCLES));

    // Buffer contents after shifting in the current sample's digit.
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign w_entry_shift = w_enc;
        end else begin : g_multi_digit
            assign w_entry_shift = {r_entry[4*DIGITS-5:0], w_enc};
        end
    endgenerate

    // Input sampling and the registered stable-sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ksmp       <= {KEYS{1'b0}};
            r_kprev      <= {KEYS{1'b0}};
            r_stable_cnt <= {SW{1'b0}};
        end else begin
            r_ksmp       <= keypad;
            r_kprev      <= r_ksmp;
            r_stable_cnt <= w_stable_cnt;
        end
    end

    // Stable count including the newest sample, so a decision can be taken
    // on the same edge the DEBOUNCE_CYCLES-th matching sample is seen.
    always_comb begin
        w_stable_cnt = {SW{1'b0}};
        if (r_ksmp != r_kprev) begin
            w_stable_cnt = {SW{1'b0}};
        end else if (r_stable_cnt == SW'(DEBOUNCE_CYCLES)) begin
            w_stable_cnt = r_stable_cnt;
        end else begin
            w_stable_cnt = r_stable_cnt + SW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and accept/reject decisions.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
`ifdef KEYPAD_MULTI_ERR_EN
        w_reject     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_sample_nz) begin
                    w_state_next = S_PRESS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_PRESS: begin
                if (!w_sample_nz) begin
                    w_state_next = S_IDLE;
                end else if (w_stable) begin
`ifdef KEYPAD_MULTI_ERR_EN
                    if (f_multi_hot(r_ksmp)) begin
                        // Rejected press still has to be released before the next one.
                        w_reject     = 1'b1;
                        w_state_next = S_HELD;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = S_ACCEPT;
                    end
`else
                    w_accept     = 1'b1;
                    w_state_next = S_ACCEPT;
`endif
                end else begin
                    w_state_next = S_PRESS;
                end
            end
            S_ACCEPT: begin
                w_state_next = S_HELD;
            end
            S_HELD: begin
                if (!w_sample_nz) begin
                    w_state_next = S_RELEASE;
                end else begin
                    w_state_next = S_HELD;
                end
            end
            S_RELEASE: begin
                if (w_sample_nz) begin
                    w_state_next = S_HELD;
                end else if (w_stable) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RELEASE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs: strobes, digit, entry buffer and count.
    // The strobe is registered on the edge that enters ACCEPT, so it is high
    // exactly during the ACCEPT cycle together with the updated buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit_valid <= 1'b0;
            r_digit       <= 4'd0;
            r_entry       <= {(4*DIGITS){1'b0}};
            r_count       <= {CW{1'b0}};
            r_multi_err   <= 1'b0;
        end else begin
            r_digit_valid <= w_accept;
            if (w_accept) begin
                r_digit <= w_enc;
            end else begin
                r_digit <= r_digit;
            end
            // clear wins over a simultaneous accept
            if (clear) begin
                r_entry <= {(4*DIGITS){1'b0}};
                r_count <= {CW{1'b0}};
            end else if (w_accept) begin
                r_entry <= w_entry_shift;
                if (r_count != CW'(DIGITS)) begin
                    r_count <= r_count + CW'(1);
                end else begin
                    r_count <= r_count;
                end
            end else begin
                r_entry <= r_entry;
                r_count <= r_count;
            end
`ifdef KEYPAD_MULTI_ERR_EN
            r_multi_err <= w_reject;
`else
            r_multi_err <= 1'b0;
`endif
        end
    end

    assign digit_valid = r_digit_valid;
    assign digit       = r_digit;
    assign entry       = r_entry;
    assign count       = r_count;
    assign multi_err   = r_multi_err;

endmodule

// File: tb/tb_keypad_entry.sv
// ---------------------------------------------------------------------------
// tb_keypad_entry
//
// Directed, self-checking bench for keypad_entry with default parameters
// (KEYS=10, DEBOUNCE_CYCLES=4, DIGITS=4). A table of press records drives
// the main digit-entry function; hand-written sequences cover reset with a
// held key, bouncing, clear coinciding with an accept and reset mid-press.
// ---------------------------------------------------------------------------
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  keypad;
    logic        clear;
    logic        digit_valid;
    logic [3:0]  digit;
    logic [15:0] entry;
    logic [2:0]  count;
    logic        multi_err;

    int n_checks = 0;
    int n_pass   = 0;

    // strobe observation state
    int          s_cnt;
    int          s_first;
    logic [3:0]  s_digit;
    logic [15:0] s_entry;
    logic [2:0]  s_count;
    int          m_cnt;

    typedef struct {
        logic [9:0]  keys;
        int          hold;
        int          exp_strobes;
        logic [3:0]  exp_digit;
        logic [15:0] exp_entry;
        logic [2:0]  exp_count;
        int          exp_multi;
    } press_t;

    press_t tbl [8];

    always #5 clk = ~clk;

    keypad_entry #(
        .KEYS(10),
        .DEBOUNCE_CYCLES(4),
        .DIGITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keypad(keypad),
        .clear(clear),
        .digit_valid(digit_valid),
        .digit(digit),
        .entry(entry),
        .count(count),
        .multi_err(multi_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_reset();
        s_cnt   = 0;
        s_first = -1;
        s_digit = 4'd0;
        s_entry = 16'd0;
        s_count = 3'd0;
        m_cnt   = 0;
    endtask

    // One clock step, recording strobes; idx is the edge number since the key went down.
    task automatic step_obs(input int idx);
        tick();
        if (digit_valid === 1'b1) begin
            s_cnt++;
            if (s_cnt == 1) begin
                s_first = idx;
                s_digit = digit;
                s_entry = entry;
                s_count = count;
            end
        end
        if (multi_err === 1'b1) begin
            m_cnt++;
        end
    endtask

    task automatic release_keys();
        keypad = 10'd0;
        for (int r = 0; r < 14; r++) begin
            step_obs(0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{10'b0000001000, 20, 1, 4'd3, 16'h0003, 3'd1, 0};
        tbl[1] = '{10'b0000000010,  8, 1, 4'd1, 16'h0031, 3'd2, 0};
        tbl[2] = '{10'b0000000100,  8, 1, 4'd2, 16'h0312, 3'd3, 0};
        tbl[3] = '{10'b0000001000,  8, 1, 4'd3, 16'h3123, 3'd4, 0};
        tbl[4] = '{10'b0000010000,  8, 1, 4'd4, 16'h1234, 3'd4, 0};
        tbl[5] = '{10'b0000100000,  8, 1, 4'd5, 16'h2345, 3'd4, 0};
`ifdef KEYPAD_MULTI_ERR_EN
        tbl[6] = '{10'b1000000001,  8, 0, 4'd5, 16'h2345, 3'd4, 1};
        tbl[7] = '{10'b0010000000,  8, 1, 4'd7, 16'h3457, 3'd4, 0};
`else
        tbl[6] = '{10'b1000000001,  8, 1, 4'd9, 16'h3459, 3'd4, 0};
        tbl[7] = '{10'b0010000000,  8, 1, 4'd7, 16'h4597, 3'd4, 0};
`endif

        // Reset with key 9 held: outputs zero, then exactly one press after 6 edges
        rst    = 1'b1;
        clear  = 1'b0;
        keypad = 10'b1000000000;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check("rst_digit_valid", 32'(digit_valid), 32'd0);
        check("rst_digit",       32'(digit),       32'd0);
        check("rst_entry",       32'(entry),       32'd0);
        check("rst_count",       32'(count),       32'd0);
        check("rst_multi_err",   32'(multi_err),   32'd0);
        rst = 1'b0;
        obs_reset();
        for (int i = 1; i <= 10; i++) begin
            step_obs(i);
        end
        release_keys();
        check("rst_held_strobes", 32'(s_cnt),   32'd1);
        check("rst_held_latency", 32'(s_first), 32'd6);
        check("rst_held_digit",   32'(s_digit), 32'd9);
        check("rst_held_entry",   32'(entry),   32'h0009);
        check("rst_held_count",   32'(count),   32'd1);

        // Plain clear pulse
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear1_entry", 32'(entry), 32'd0);
        check("clear1_count", 32'(count), 32'd0);

        // Table-driven presses
        for (int t = 0; t < 8; t++) begin
            obs_reset();
            keypad = tbl[t].keys;
            for (int h = 1; h <= tbl[t].hold; h++) begin
                step_obs(h);
            end
            release_keys();
            check($sformatf("tbl%0d_strobes", t), 32'(s_cnt), 32'(tbl[t].exp_strobes));
            check($sformatf("tbl%0d_multi", t),   32'(m_cnt), 32'(tbl[t].exp_multi));
            if (tbl[t].exp_strobes == 1) begin
                check($sformatf("tbl%0d_latency", t),      32'(s_first), 32'd6);
                check($sformatf("tbl%0d_strobe_digit", t), 32'(s_digit), 32'(tbl[t].exp_digit));
                check($sformatf("tbl%0d_strobe_entry", t), 32'(s_entry), 32'(tbl[t].exp_entry));
                check($sformatf("tbl%0d_strobe_count", t), 32'(s_count), 32'(tbl[t].exp_count));
            end
            check($sformatf("tbl%0d_digit_hold", t), 32'(digit), 32'(tbl[t].exp_digit));
            check($sformatf("tbl%0d_entry", t),      32'(entry), 32'(tbl[t].exp_entry));
            check($sformatf("tbl%0d_count", t),      32'(count), 32'(tbl[t].exp_count));
        end

        // Clear pulse on a full buffer
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear2_entry", 32'(entry), 32'd0);
        check("clear2_count", 32'(count), 32'd0);

        // Bouncing key 0: no strobe until it settles, then exactly one
        obs_reset();
        for (int c = 0; c < 10; c++) begin
            keypad = (((c / 2) % 2) == 0) ? 10'b0000000001 : 10'b0000000000;
            step_obs(0);
        end
        check("bounce_no_strobe", 32'(s_cnt), 32'd0);
        for (int h = 1; h <= 12; h++) begin
            step_obs(h);
        end
        release_keys();
        check("bounce_strobes",       32'(s_cnt),   32'd1);
        check("bounce_strobe_digit",  32'(s_digit), 32'd0);
        check("bounce_strobe_count",  32'(s_count), 32'd1);

        // Normal press of 8 to put a nonzero digit in the buffer
        obs_reset();
        keypad = 10'b0100000000;
        for (int h = 1; h <= 8; h++) begin
            step_obs(h);
        end
        release_keys();
        check("press8_latency", 32'(s_first), 32'd6);
        check("press8_entry",   32'(entry),   32'h0008);
        check("press8_count",   32'(count),   32'd2);

        // clear on the same edge the accept is registered
        keypad = 10'b0001000000;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("clracc_pre_strobe", 32'(digit_valid), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clracc_digit_valid", 32'(digit_valid), 32'd1);
        check("clracc_digit",       32'(digit),       32'd6);
        check("clracc_entry",       32'(entry),       32'd0);
        check("clracc_count",       32'(count),       32'd0);
        tick();
        check("clracc_one_cycle",   32'(digit_valid), 32'd0);
        release_keys();

        // rst mid-PRESS: no strobe, and the next press has full latency from IDLE
        keypad = 10'b0000000100;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        check("midrst_digit", 32'(digit), 32'd0);
        check("midrst_dv",    32'(digit_valid), 32'd0);
        rst = 1'b0;
        keypad = 10'd0;
        obs_reset();
        for (int i = 0; i < 14; i++) begin
            step_obs(0);
        end
        check("midrst_no_strobe", 32'(s_cnt), 32'd0);
        obs_reset();
        keypad = 10'b0000000100;
        for (int h = 1; h <= 8; h++) begin
            step_obs(h);
        end
        release_keys();
        check("postrst_strobes", 32'(s_cnt),   32'd1);
        check("postrst_latency", 32'(s_first), 32'd6);
        check("postrst_digit",   32'(s_digit), 32'd2);
        check("postrst_entry",   32'(entry),   32'h0002);
        check("postrst_count",   32'(count),   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
